// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send,
// shifts a command byte out LSB first with odd parity and checks the ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       psClk,
   input  logic       psData,
   output logic       psClk_oe,
   output logic       psData_oe,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_Start,
   output logic       Busy,
   output logic       Done,
   output logic       Error
);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      WAIT_REL
   } state_t;

   localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        clk_s1_q, clk_s1_d;
   logic        clk_s2_q, clk_s2_d;
   logic        clk_prev_q, clk_prev_d;
   logic        dat_s1_q, dat_s1_d;
   logic        dat_s2_q, dat_s2_d;
   logic [7:0]  byte_q, byte_d;
   logic        par_q, par_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [19:0] inh_cnt_q, inh_cnt_d;
   logic [19:0] to_cnt_q, to_cnt_d;
   logic        clk_oe_q, clk_oe_d;
   logic        dat_oe_q, dat_oe_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        fall;
   logic [3:0]  bit_nxt;
   logic [2:0]  bit_idx;
   logic [19:0] inh_nxt;
   logic [19:0] to_nxt;

   assign fall    = clk_prev_q & ~clk_s2_q;
   assign bit_nxt = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;
   assign bit_idx = 3'(bit_nxt - 4'd1);
   assign inh_nxt = (&inh_cnt_q) ? inh_cnt_q : inh_cnt_q + 20'd1;
   assign to_nxt  = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 20'd1;

   // Next-state, synchronizer and registered-output computation
   always_comb begin
      state_d    = state_q;
      clk_s1_d   = psClk;
      clk_s2_d   = clk_s1_q;
      clk_prev_d = clk_s2_q;
      dat_s1_d   = psData;
      dat_s2_d   = dat_s1_q;
      byte_d     = byte_q;
      par_d      = par_q;
      bit_cnt_d  = bit_cnt_q;
      inh_cnt_d  = inh_cnt_q;
      to_cnt_d   = to_cnt_q;
      clk_oe_d   = clk_oe_q;
      dat_oe_d   = dat_oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            // a request coinciding with a Done/Error pulse is dropped
            if (Tx_Start && !done_q && !err_q) begin
               byte_d    = Tx_Data;
               par_d     = ~^Tx_Data;
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               busy_d    = 1'b1;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt_q >= INH_LAST) begin
               dat_oe_d = 1'b1;
               state_d  = REQ;
            end else begin
               inh_cnt_d = inh_nxt;
            end
         end
         REQ: begin
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b1;
            bit_cnt_d = '0;
            // counter holds cycles elapsed since the REQ cycle
            to_cnt_d  = 20'd1;
            state_d   = SHIFT;
         end
         SHIFT, ACK, WAIT_REL: begin
            if (to_cnt_q >= TO_LAST) begin
               clk_oe_d = 1'b0;
               dat_oe_d = 1'b0;
               busy_d   = 1'b0;
               err_d    = 1'b1;
               state_d  = IDLE;
            end else begin
               to_cnt_d = to_nxt;
               if (state_q == SHIFT) begin
                  if (fall) begin
                     bit_cnt_d = bit_nxt;
                     if (bit_nxt <= 4'd8) begin
                        dat_oe_d = ~byte_q[bit_idx];
                     end else if (bit_nxt == 4'd9) begin
                        dat_oe_d = ~par_q;
                     end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                     end
                  end
               end else if (state_q == ACK) begin
                  if (fall) begin
                     if (!dat_s2_q) begin
                        state_d = WAIT_REL;
                     end else begin
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = IDLE;
                     end
                  end
               end else begin
                  if (clk_s2_q && dat_s2_q) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   // State, counters, synchronizers and outputs; reset releases the bus at once
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         byte_q     <= '0;
         par_q      <= 1'b0;
         bit_cnt_q  <= '0;
         inh_cnt_q  <= '0;
         to_cnt_q   <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         clk_prev_q <= clk_prev_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         byte_q     <= byte_d;
         par_q      <= par_d;
         bit_cnt_q  <= bit_cnt_d;
         inh_cnt_q  <= inh_cnt_d;
         to_cnt_q   <= to_cnt_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign psClk_oe  = clk_oe_q;
   assign psData_oe = dat_oe_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Error     = err_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000: number of Clk cycles the PS/2 clock is held low (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000: maximum Clk cycles from leaving inhibit to completion (15 ms).
REQ-003 Clk  in  1  system clock, 50 MHz; single clock domain.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 psClk  in  1  raw PS/2 clock line (asynchronous).
REQ-006 psData  in  1  raw PS/2 data line (asynchronous).
REQ-007 psClk_oe  out  1  1 pulls the clock line low; 0 releases it.
REQ-008 psData_oe  out  1  1 pulls the data line low; 0 releases it.
REQ-009 Tx_Data  in  8  command byte to the keyboard, e.g. 0xED LED set, 0xFF reset.
REQ-010 Tx_Start  in  1  single-cycle request; sampled only in IDLE.
REQ-011 Busy  out  1  high from the cycle after accept until return to IDLE.
REQ-012 Done  out  1  one-cycle pulse on successful, acknowledged transfer.
REQ-013 Error  out  1  one-cycle pulse on NACK or timeout.

Function
REQ-014 psClk and psData SHALL each pass through a 2-flop synchronizer; a falling edge is defined as synchronized previous=1 and current=0, detected one cycle after the second flop.
REQ-015 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL.
REQ-016 IDLE: psClk_oe=0 and psData_oe=0; Tx_Start=1 latches Tx_Data and the odd parity bit (~^Tx_Data), then transitions to INHIBIT with Busy=1 on the next cycle.
REQ-017 INHIBIT: psClk_oe=1 and psData_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-018 REQ (1 cycle): psClk_oe=1 and psData_oe=1 (start bit 0); then SHIFT with psClk_oe=0, psData_oe=1; the bit counter is cleared and the timeout counter is started.
REQ-019 SHIFT: on falling edges 1-8, psData_oe=~Tx_Data[n-1] (LSB first); on edge 9, psData_oe=~parity; on edge 10, psData_oe=0 (stop bit released); then ACK.
REQ-020 ACK: on the next (11th) falling edge, sample synchronized psData; 0 transitions to WAIT_REL, 1 flags NACK.
REQ-021 WAIT_REL: wait until synchronized psClk=1 and psData=1, then pulse Done for 1 cycle and enter IDLE (Busy=0 in the same cycle).
REQ-022 NACK: pulse Error for 1 cycle and enter IDLE, with lines released.
REQ-023 Timeout: if the timeout counter reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_REL, release both lines, pulse Error for 1 cycle and enter IDLE; Done SHALL NOT pulse.
REQ-024 Done and Error SHALL never be high in the same cycle.
REQ-025 Tx_Start while Busy=1 SHALL be ignored, with no effect on the latched byte.
REQ-026 Tx_Start in the same cycle as a Done/Error pulse SHALL be ignored; it is accepted on a later IDLE cycle only.
REQ-027 Counters: inhibit and timeout counters are 20 bits and saturate; the bit counter is 4 bits; none SHALL wrap.
REQ-028 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.

Reset
REQ-029 Reset=1 SHALL asynchronously force IDLE, psClk_oe=0, psData_oe=0, Busy=0, Done=0, Error=0, clear all counters and the latched byte, and clear the synchronizers to 1.
REQ-030 Reset asserted mid-transfer SHALL release both lines immediately, with no Done or Error pulse.
REQ-031 The first Tx_Start after Reset deasserts SHALL be accepted normally.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks at 20 Clk/half-period)
REQ-032 Send 0xED with the model ACKing: psClk_oe high 20 cycles; bits sampled by the model are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; Done pulses once; Busy is low afterwards.
REQ-033 Send 0xF4: sampled parity is 0; Done=1 for one cycle; Error stays 0.
REQ-034 Send 0x00 with the model driving ACK=1 (NACK) on the 11th edge: Error pulses once, Done=0, both oe=0 in the next cycle.
REQ-035 Send 0xFF with the model stopping after 5 clocks: Error pulses 2000 cycles after REQ; both lines are released.
REQ-036 Assert Reset during data bit 4: psClk_oe=psData_oe=Busy=0 immediately; a following 0xED transfer completes with Done.
REQ-037 Pulse Tx_Start=0xAA while Busy during a 0xED transfer: the model receives 0xED only, and exactly one Done pulse occurs.
